// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    // Width of the word-count header carried at the front of the stream.
    localparam int LEN_W          = 16;
    // Stream bytes per instruction word.
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        CHECK,
        DATA,
        WRITE,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles little-endian stream bytes into a 32-bit word: the first byte
// lands in [7:0], the fourth in [31:24].
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_byte_o
);

    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [31:0] word_q;
    logic [31:0] word_d;

    // Next-state: clear restarts assembly, load inserts the byte at the current lane.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                        = idx_q + 2'd1;
        end
    end

    // Byte index and partial word; reset discards any partially assembled word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign last_byte_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Instruction-memory loader and processor reset sequencer. Reads a 16-bit
// word count followed by that many little-endian words, writes each word to
// instruction memory, and releases the processor only once all are written.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Length check is one bit wider than the header so a full 2^16-word
    // memory is still a legal length.
    localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    logic        hs;
    logic        pk_clear;
    logic        pk_load;
    logic        pk_last;
    logic [31:0] pk_word;

    byte_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .load_i      (pk_load),
        .byte_i      (rx_data),
        .word_o      (pk_word),
        .last_byte_o (pk_last)
    );

    // Moore outputs decoded from the registered state.
    always_comb begin
        rx_ready  = 1'b0;
        imem_we   = 1'b0;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            LEN0, LEN1, DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            CHECK: busy = 1'b1;
            WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
            end
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    assign hs         = rx_valid & rx_ready;
    assign imem_addr  = addr_q;
    assign imem_wdata = pk_word;

    // Next-state logic: header capture, length validation, byte/word sequencing.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        case (state_q)
            LEN0: begin
                if (hs) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (hs) begin
                    len_d[15:8] = rx_data;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if ((len_q == '0) || ({1'b0, len_q} > DEPTH)) begin
                    state_d = ERR;
                end else begin
                    addr_d   = '0;
                    pk_clear = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    pk_load = 1'b1;
                    if (pk_last) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (LEN_W'(addr_q) == (len_q - LEN_W'(1))) begin
                    state_d = RUN;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = DATA;
                end
            end
            RUN, ERR: begin
                if (reload) begin
                    state_d = LEN0;
                end
            end
            default: state_d = LEN0;
        endcase
    end

    // State, length and word-address registers; reset returns to LEN0 at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LEN0;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: streams randomized programs and compares the
// observed instruction-memory writes with the words that were sent.
module tb_program_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int n_pass = 0;
    int n_chk  = 0;

    // Words sent in the current stream (reference model) and writes observed.
    logic [31:0]       exp_words[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];
    int                we_bad = 0;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write monitor: records every memory write and flags any made while the CPU runs.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            if (cpu_reset !== 1'b1) we_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_stall, output bit ok);
        int st;
        st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        rx_valid = 1'b0;
        repeat (st) begin
            @(posedge clk); @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rx_ready === 1'b1) ok = 1'b1;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic stream(input logic [15:0] len, input bit with_data, input int max_stall,
                          output bit ok);
        bit b;
        ok = 1'b1;
        send_byte(len[7:0], max_stall, b);  ok = ok & b;
        send_byte(len[15:8], max_stall, b); ok = ok & b;
        if (with_data) begin
            for (int k = 0; k < exp_words.size(); k++) begin
                for (int j = 0; j < 4; j++) begin
                    send_byte(exp_words[k][8*j +: 8], max_stall, b);
                    ok = ok & b;
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            if (done === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk); @(negedge clk);
            end
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cpu_reset, rx_ready, busy, imem_we, done, error} !== 6'b111000) begin
            $display("FAIL reset_flags got %b want 111000",
                     {cpu_reset, rx_ready, busy, imem_we, done, error});
        end else n_pass++;
        n_chk++;
        if ({imem_addr, imem_wdata} !== '0) begin
            $display("FAIL reset_bus got addr=%h data=%h want 0", imem_addr, imem_wdata);
        end else n_pass++;
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        n_chk++;
        if ({cpu_reset, rx_ready, busy, done} !== 4'b1110) begin
            $display("FAIL reset_release got %b want 1110", {cpu_reset, rx_ready, busy, done});
        end else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        wa.delete(); wd.delete();
        exp_words = '{32'h12345678};
        stream(16'd1, 1'b1, 0, ok);
        n_chk++;
        if (!ok) $display("FAIL basic_stream got timeout want accepted");
        else n_pass++;
        n_chk++;
        if ({imem_we, cpu_reset, rx_ready} !== 3'b110 || imem_addr !== '0 ||
            imem_wdata !== 32'h12345678) begin
            $display("FAIL basic_write got we=%b rst=%b rdy=%b addr=%h data=%h want 1 1 0 00 12345678",
                     imem_we, cpu_reset, rx_ready, imem_addr, imem_wdata);
        end else n_pass++;
        @(posedge clk); @(negedge clk);
        n_chk++;
        if ({done, cpu_reset, imem_we, busy} !== 4'b1000) begin
            $display("FAIL basic_run got done/rst/we/busy=%b want 1000",
                     {done, cpu_reset, imem_we, busy});
        end else n_pass++;
        n_chk++;
        if (wa.size() != 1) $display("FAIL basic_count got %0d want 1", wa.size());
        else n_pass++;
    endtask

    task automatic test_multi_stall();
        bit ok;
        pulse_reload();
        wa.delete(); wd.delete(); we_bad = 0;
        exp_words.delete();
        for (int k = 0; k < 3; k++) exp_words.push_back($urandom);
        stream(16'd3, 1'b1, 3, ok);
        wait_done(100, ok);
        n_chk++;
        if (!ok) $display("FAIL multi_done got done=%b want 1", done);
        else n_pass++;
        n_chk++;
        if (wa.size() != 3) $display("FAIL multi_count got %0d want 3", wa.size());
        else n_pass++;
        for (int k = 0; k < 3 && k < wa.size(); k++) begin
            n_chk++;
            if (wa[k] !== ADDR_W'(k) || wd[k] !== exp_words[k]) begin
                $display("FAIL multi_word%0d got addr=%h data=%h want addr=%h data=%h",
                         k, wa[k], wd[k], ADDR_W'(k), exp_words[k]);
            end else n_pass++;
        end
        n_chk++;
        if (we_bad != 0) $display("FAIL multi_we_in_run got %0d want 0", we_bad);
        else n_pass++;
    endtask

    task automatic test_bounds();
        bit ok;
        logic [15:0] bad_len[2];
        bad_len[0] = 16'd0;
        bad_len[1] = 16'd257;
        for (int t = 0; t < 2; t++) begin
            pulse_reload();
            wa.delete(); wd.delete();
            stream(bad_len[t], 1'b0, 1, ok);
            rx_data = 8'hA5; rx_valid = 1'b1;
            repeat (3) begin
                @(posedge clk); @(negedge clk);
            end
            n_chk++;
            if ({error, cpu_reset, busy, rx_ready, done} !== 5'b11000 || wa.size() != 0) begin
                $display("FAIL bounds_len%0d got err/rst/busy/rdy/done=%b writes=%0d want 11000 0",
                         bad_len[t], {error, cpu_reset, busy, rx_ready, done}, wa.size());
            end else n_pass++;
            rx_valid = 1'b0;
            pulse_reload();
            n_chk++;
            if ({error, rx_ready, busy, cpu_reset} !== 4'b0111) begin
                $display("FAIL bounds_reload%0d got err/rdy/busy/rst=%b want 0111",
                         bad_len[t], {error, rx_ready, busy, cpu_reset});
            end else n_pass++;
        end
        // Full-capacity load of 256 words, ending at address 0xFF.
        wa.delete(); wd.delete();
        exp_words.delete();
        for (int k = 0; k < 256; k++) exp_words.push_back($urandom);
        stream(16'd256, 1'b1, 0, ok);
        wait_done(20, ok);
        n_chk++;
        if (!ok || wa.size() != 256) begin
            $display("FAIL bounds_full got done=%b writes=%0d want 1 256", done, wa.size());
        end else n_pass++;
        for (int k = 0; k < wa.size() && k < 256; k++) begin
            n_chk++;
            if (wa[k] !== ADDR_W'(k) || wd[k] !== exp_words[k]) begin
                $display("FAIL bounds_word%0d got addr=%h data=%h want addr=%h data=%h",
                         k, wa[k], wd[k], ADDR_W'(k), exp_words[k]);
            end else n_pass++;
        end
        n_chk++;
        if (wa.size() == 0 || wa[wa.size()-1] !== 8'hFF) begin
            $display("FAIL bounds_last_addr got %h want ff",
                     (wa.size() == 0) ? 8'h00 : wa[wa.size()-1]);
        end else n_pass++;
    endtask

    task automatic test_reload();
        bit ok;
        bit b;
        pulse_reload();
        n_chk++;
        if ({cpu_reset, rx_ready, done} !== 3'b110) begin
            $display("FAIL reload_enter got rst/rdy/done=%b want 110", {cpu_reset, rx_ready, done});
        end else n_pass++;
        wa.delete(); wd.delete();
        ok = 1'b1;
        send_byte(8'h01, 0, b); ok = ok & b;
        send_byte(8'h00, 0, b); ok = ok & b;
        send_byte(8'hEF, 0, b); ok = ok & b;
        send_byte(8'hBE, 0, b); ok = ok & b;
        rx_valid = 1'b0;
        pulse_reload();
        n_chk++;
        if ({busy, rx_ready, error, done} !== 4'b1100) begin
            $display("FAIL reload_in_data got busy/rdy/err/done=%b want 1100",
                     {busy, rx_ready, error, done});
        end else n_pass++;
        send_byte(8'hAD, 0, b); ok = ok & b;
        send_byte(8'hDE, 0, b); ok = ok & b;
        rx_valid = 1'b0;
        wait_done(10, b); ok = ok & b;
        n_chk++;
        if (!ok || wa.size() != 1 || wa[0] !== '0 || wd[0] !== 32'hDEADBEEF) begin
            $display("FAIL reload_write got ok=%b writes=%0d data=%h want 1 1 deadbeef",
                     ok, wa.size(), (wd.size() > 0) ? wd[0] : 32'h0);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        bit b;
        pulse_reload();
        wa.delete(); wd.delete();
        send_byte(8'h02, 0, b);
        send_byte(8'h00, 0, b);
        send_byte(8'h11, 0, b);
        send_byte(8'h22, 0, b);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({cpu_reset, rx_ready, busy, imem_we, done, error} !== 6'b111000 ||
            imem_addr !== '0 || imem_wdata !== '0) begin
            $display("FAIL async_mid_word got flags=%b addr=%h data=%h want 111000 00 00000000",
                     {cpu_reset, rx_ready, busy, imem_we, done, error}, imem_addr, imem_wdata);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_words = '{$urandom};
        stream(16'd1, 1'b1, 2, ok);
        wait_done(20, b); ok = ok & b;
        n_chk++;
        if (!ok || wa.size() != 1 || wa[0] !== '0 || wd[0] !== exp_words[0]) begin
            $display("FAIL async_reload got ok=%b writes=%0d data=%h want 1 1 %h",
                     ok, wa.size(), (wd.size() > 0) ? wd[0] : 32'h0, exp_words[0]);
        end else n_pass++;
        // Reset from RUN must raise cpu_reset without waiting for a clock edge.
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({cpu_reset, done, rx_ready} !== 3'b101) begin
            $display("FAIL async_from_run got rst/done/rdy=%b want 101", {cpu_reset, done, rx_ready});
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_stall();
        test_bounds();
        test_reload();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction-memory loader and reset sequencer for the single-cycle MIPS processor. It accepts a byte stream (length header followed by little-endian 32-bit words) over a valid/ready interface and writes each word into instruction memory. The processor is held in reset throughout and released only after the last word is written. On a `reload` request from the run state, it re-enters loading and reasserts processor reset.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width.
  - Capacity is DEPTH = 2^ADDR_W words.

Ports:
- `clk`  in  1  — single clock; all logic is on its rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `rx_data`  in  8  — stream byte.
- `rx_valid`  in  1  — byte valid.
  - The source holds `rx_data` stable until it is accepted.
- `rx_ready`  out  1  — loader can accept a byte.
  - A handshake occurs when `rx_valid & rx_ready` is high at the clock edge.
- `reload`  in  1  — single-cycle request to start a new load.
  - Honoured only in RUN or ERR.
- `imem_we`  out  1  — instruction-memory write enable, one cycle per word.
- `imem_addr`  out  ADDR_W  — word address of the write.
- `imem_wdata`  out  32  — assembled word.
- `cpu_reset`  out  1  — processor reset; high except in RUN.
- `busy`  out  1  — high in LEN0, LEN1, CHECK, DATA and WRITE.
- `done`  out  1  — high in RUN.
- `error`  out  1  — high in ERR.

## Operation
Stream format:
- Bytes 0 and 1 carry the word count N, a 16-bit value, little-endian.
- Then N×4 data bytes follow.
- Each word is little-endian: its first byte goes to [7:0] and its fourth byte to [31:24].

States (registered, Moore outputs):
- **LEN0**: `rx_ready`=1. On handshake, len[7:0] ← `rx_data`; go to LEN1.
- **LEN1**: `rx_ready`=1. On handshake, len[15:8] ← `rx_data`; go to CHECK.
- **CHECK**: `rx_ready`=0, lasts one cycle.
  - If len==0 or len>DEPTH, go to ERR.
  - Otherwise clear word_addr and byte_idx, and go to DATA.
- **DATA**: `rx_ready`=1. On handshake, word[8·byte_idx +: 8] ← `rx_data` and byte_idx increments (2 bits, wraps).
  - A handshake with byte_idx==3 moves to WRITE.
- **WRITE**: `rx_ready`=0, `imem_we`=1 for exactly one cycle, with `imem_addr`=word_addr and `imem_wdata`=word.
  - If word_addr==len−1, go to RUN.
  - Otherwise word_addr increments and the state returns to DATA.
- **RUN**: `cpu_reset`=0, `done`=1, `rx_ready`=0. `reload`=1 moves to LEN0.
- **ERR**: `cpu_reset`=1, `error`=1, `rx_ready`=0. `reload`=1 moves to LEN0.

Rules:
- `reload` is ignored in all states other than RUN and ERR.
- Bytes arriving in RUN or ERR are not accepted (`rx_ready`=0).
- `rx_valid` low while `rx_ready`=1: the state holds and no counter changes.
- Width checks: the len comparison against DEPTH is done at 17 bits, so DEPTH=65536 is legal when ADDR_W=16. word_addr is ADDR_W bits, and the last address is DEPTH−1 with no wrap.
- `imem_addr` and `imem_wdata` are don't-care when `imem_we`=0; they are driven from registers.

## Timing
- Reset values: state=LEN0, `cpu_reset`=1, `rx_ready`=1, `busy`=1, `imem_we`=0, `done`=0, `error`=0, and `imem_addr`, `imem_wdata` and all counters are 0.
- Reset mid-load takes effect immediately (asynchronously):
  - the partial word and length are discarded;
  - memory contents already written are left untouched;
  - `cpu_reset` rises asynchronously.
- Best-case schedule, with the first length byte accepted in cycle 0:
  - LEN1 handshake in cycle 1;
  - CHECK in cycle 2;
  - word k is written in cycle 7+5k;
  - RUN, with `cpu_reset` low, begins in cycle 3+5N.
- Per-word throughput is 5 cycles (4 bytes plus 1 write bubble).
- `imem_we` asserts in the cycle immediately after the fourth byte handshake.
- `reload` sampled in RUN at edge t: `cpu_reset` is high and `rx_ready` is high from cycle t+1.

## Structure
- Package `loader_pkg`:
  - state enum {LEN0, LEN1, CHECK, DATA, WRITE, RUN, ERR};
  - `LEN_W`=16;
  - `BYTES_PER_WORD`=4.
- Sub-module `byte_word_packer`:
  - holds the byte_idx counter and the 32-bit shift/insert register;
  - inputs: load strobe, byte, clear;
  - outputs: word, last_byte.
- The top level holds the FSM, the len register and the word_addr counter.

## Test plan
- **Basic load**: stream 01 00 78 56 34 12 with `rx_valid` held high → one `imem_we` pulse at addr 0, data 0x12345678; `cpu_reset` falls 1 cycle later; `done`=1.
- **Multi-word with stalls**: N=3, `rx_valid` toggled randomly → exactly 3 writes at addresses 0, 1, 2 with the correct words; no write during a stall; RUN only after the third write.
- **Bounds**:
  - len=0 → ERR with `error`=1, no writes, `cpu_reset` stays 1;
  - len=257 with ADDR_W=8 → ERR;
  - len=256 → 256 writes, the last at addr 0xFF.
- **Reload**: after RUN, pulse `reload`, then stream N=1, data 0xDEADBEEF → `cpu_reset` high the next cycle; one write at addr 0; return to RUN. A `reload` pulse during DATA is ignored.
- **Async reset mid-word**: assert `reset` after 2 data bytes → outputs at reset values immediately; a fresh stream loads correctly from the LEN0 state.
